proc_core: RTL and testbench

- Minimal MOS 6502-compatible processor core.
- Supports the immediate, absolute and implied instruction subset, running against a byte-wide synchronous RAM.
- The RAM is clocked 10x faster than the core, so read data is valid within one core cycle.
- Sits beside memory_block at top level and drives its address, write-data and write-enable ports.

---
 rtl/proc_pkg.sv | 94 +++++++++
 rtl/proc_alu.sv | 52 +++++
 rtl/proc_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_proc_core.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared types, opcode constants and decode helpers for the proc_core 6502 subset.
package proc_pkg;

    typedef enum logic [2:0] {
        RST_LO, RST_HI, FETCH, DECODE, ABS_HI, EXEC_RD, EXEC_WR
    } state_e;

    typedef enum logic [2:0] {
        ADD, SUB, AND, OR, XOR, CMP, PASS
    } alu_op_e;

    typedef enum logic [2:0] {
        AM_IMPL, AM_IMM, AM_ABS_RD, AM_ABS_WR, AM_JMP
    } addr_mode_e;

    typedef enum logic [3:0] {
        K_NONE, K_LDA, K_LDX, K_LDY, K_ADC, K_SBC, K_AND, K_ORA, K_EOR,
        K_CMP, K_CPX, K_CPY, K_BIT
    } op_kind_e;

    // Status register bit positions
    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_V = 6;
    localparam int P_N = 7;

    // Implied
    localparam logic [7:0] OP_NOP = 8'hEA, OP_TAX = 8'hAA, OP_TXA = 8'h8A;
    localparam logic [7:0] OP_TAY = 8'hA8, OP_TYA = 8'h98, OP_TXS = 8'h9A;
    localparam logic [7:0] OP_TSX = 8'hBA, OP_INX = 8'hE8, OP_INY = 8'hC8;
    localparam logic [7:0] OP_DEX = 8'hCA, OP_DEY = 8'h88, OP_CLC = 8'h18;
    localparam logic [7:0] OP_SEC = 8'h38, OP_CLD = 8'hD8, OP_SED = 8'hF8;
    localparam logic [7:0] OP_CLI = 8'h58, OP_SEI = 8'h78, OP_CLV = 8'hB8;
    // Immediate
    localparam logic [7:0] OP_LDA_IMM = 8'hA9, OP_LDX_IMM = 8'hA2, OP_LDY_IMM = 8'hA0;
    localparam logic [7:0] OP_ADC_IMM = 8'h69, OP_SBC_IMM = 8'hE9, OP_AND_IMM = 8'h29;
    localparam logic [7:0] OP_ORA_IMM = 8'h09, OP_EOR_IMM = 8'h49, OP_CMP_IMM = 8'hC9;
    localparam logic [7:0] OP_CPX_IMM = 8'hE0, OP_CPY_IMM = 8'hC0;
    // Absolute
    localparam logic [7:0] OP_LDA_ABS = 8'hAD, OP_LDX_ABS = 8'hAE, OP_LDY_ABS = 8'hAC;
    localparam logic [7:0] OP_ADC_ABS = 8'h6D, OP_SBC_ABS = 8'hED, OP_AND_ABS = 8'h2D;
    localparam logic [7:0] OP_ORA_ABS = 8'h0D, OP_EOR_ABS = 8'h4D, OP_CMP_ABS = 8'hCD;
    localparam logic [7:0] OP_CPX_ABS = 8'hEC, OP_CPY_ABS = 8'hCC, OP_BIT_ABS = 8'h2C;
    localparam logic [7:0] OP_STA_ABS = 8'h8D, OP_STX_ABS = 8'h8E, OP_STY_ABS = 8'h8C;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;

    function automatic addr_mode_e addr_mode(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDX_IMM, OP_LDY_IMM, OP_ADC_IMM, OP_SBC_IMM, OP_AND_IMM,
            OP_ORA_IMM, OP_EOR_IMM, OP_CMP_IMM, OP_CPX_IMM, OP_CPY_IMM:
                return AM_IMM;
            OP_LDA_ABS, OP_LDX_ABS, OP_LDY_ABS, OP_ADC_ABS, OP_SBC_ABS, OP_AND_ABS,
            OP_ORA_ABS, OP_EOR_ABS, OP_CMP_ABS, OP_CPX_ABS, OP_CPY_ABS, OP_BIT_ABS:
                return AM_ABS_RD;
            OP_STA_ABS, OP_STX_ABS, OP_STY_ABS:
                return AM_ABS_WR;
            OP_JMP_ABS:
                return AM_JMP;
            default:
                return AM_IMPL;
        endcase
    endfunction

    function automatic op_kind_e op_kind(input logic [7:0] op);
        case (op)
            OP_LDA_IMM, OP_LDA_ABS: return K_LDA;
            OP_LDX_IMM, OP_LDX_ABS: return K_LDX;
            OP_LDY_IMM, OP_LDY_ABS: return K_LDY;
            OP_ADC_IMM, OP_ADC_ABS: return K_ADC;
            OP_SBC_IMM, OP_SBC_ABS: return K_SBC;
            OP_AND_IMM, OP_AND_ABS: return K_AND;
            OP_ORA_IMM, OP_ORA_ABS: return K_ORA;
            OP_EOR_IMM, OP_EOR_ABS: return K_EOR;
            OP_CMP_IMM, OP_CMP_ABS: return K_CMP;
            OP_CPX_IMM, OP_CPX_ABS: return K_CPX;
            OP_CPY_IMM, OP_CPY_ABS: return K_CPY;
            OP_BIT_ABS:             return K_BIT;
            default:                return K_NONE;
        endcase
    endfunction

    // Returns p with N and Z updated from v
    function automatic logic [7:0] set_nz(input logic [7:0] p, input logic [7:0] v);
        logic [7:0] r;
        r      = p;
        r[P_N] = v[7];
        r[P_Z] = (v == 8'h00);
        return r;
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational 8-bit ALU: binary add/subtract, compare, logic ops and pass-through.
module proc_alu
    import proc_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       carry_in,
    input  alu_op_e    op,
    output logic [7:0] result,
    output logic       c,
    output logic       v,
    output logic       n,
    output logic       z
);

    logic [8:0] w_sum;

    // Operation select; C/V pass carry_in/0 through for ops that do not define them
    always_comb begin
        w_sum  = '0;
        result = b;
        c      = carry_in;
        v      = 1'b0;
        case (op)
            ADD: begin
                w_sum  = {1'b0, a} + {1'b0, b} + {8'h00, carry_in};
                result = w_sum[7:0];
                c      = w_sum[8];
                v      = (a[7] == b[7]) && (w_sum[7] != a[7]);
            end
            SUB: begin
                w_sum  = {1'b0, a} + {1'b0, ~b} + {8'h00, carry_in};
                result = w_sum[7:0];
                c      = w_sum[8];
                v      = (a[7] != b[7]) && (w_sum[7] != a[7]);
            end
            CMP: begin
                w_sum  = {1'b0, a} + {1'b0, ~b} + 9'd1;
                result = w_sum[7:0];
                c      = w_sum[8];
            end
            AND:     result = a & b;
            OR:      result = a | b;
            XOR:     result = a ^ b;
            default: result = b;
        endcase
    end

    assign n = result[7];
    assign z = (result == 8'h00);

endmodule

// File: rtl/proc_core.sv
// Minimal 6502-compatible core: implied, immediate and absolute instructions
// against a byte-wide RAM whose read data is valid within one core cycle.
module proc_core
    import proc_pkg::*;
#(
    parameter logic [15:0] RESET_VECTOR_ADDR = 16'hFFFC,
    parameter logic [7:0]  SP_RESET          = 8'hFD
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rd_data,
    output logic [15:0] address,
    output logic [7:0]  wr_data,
    output logic        wr_enable
);

    state_e      r_state, n_state;
    logic [7:0]  r_a, r_x, r_y, r_s, r_ir, r_adl;
    logic [7:0]  n_a, n_x, n_y, n_s, n_ir, n_adl, n_p;
    logic [7:0]  P;
    logic [15:0] r_pc, n_pc, r_address, n_address;
    logic [7:0]  r_wr_data, n_wr_data;
    logic        r_wr_enable, n_wr_enable;

    addr_mode_e  w_am;
    op_kind_e    w_kind;
    alu_op_e     w_alu_op;
    logic [7:0]  w_alu_a, w_alu_res;
    logic        w_alu_c, w_alu_v, w_alu_n, w_alu_z;
    logic [15:0] w_pc_inc;
    logic        w_exec_op, w_exec_impl;

    assign address   = r_address;
    assign wr_data   = r_wr_data;
    assign wr_enable = r_wr_enable;

    assign w_am        = addr_mode(r_ir);
    assign w_kind      = op_kind(r_ir);
    assign w_pc_inc    = r_pc + 16'd1;
    // Operand-consuming instructions finish in DECODE (immediate) or EXEC_RD (absolute)
    assign w_exec_op   = ((r_state == DECODE) && (w_am == AM_IMM)) || (r_state == EXEC_RD);
    assign w_exec_impl = (r_state == DECODE) && (w_am == AM_IMPL);

    // ALU operation and left operand selected from the current instruction
    always_comb begin
        w_alu_op = PASS;
        w_alu_a  = r_a;
        case (w_kind)
            K_ADC: w_alu_op = ADD;
            K_SBC: w_alu_op = SUB;
            K_AND: w_alu_op = AND;
            K_ORA: w_alu_op = OR;
            K_EOR: w_alu_op = XOR;
            K_CMP: w_alu_op = CMP;
            K_CPX: begin w_alu_op = CMP; w_alu_a = r_x; end
            K_CPY: begin w_alu_op = CMP; w_alu_a = r_y; end
            default: ;
        endcase
    end

    proc_alu u_alu (
        .a        (w_alu_a),
        .b        (rd_data),
        .carry_in (P[P_C]),
        .op       (w_alu_op),
        .result   (w_alu_res),
        .c        (w_alu_c),
        .v        (w_alu_v),
        .n        (w_alu_n),
        .z        (w_alu_z)
    );

    // Next-state, bus and register update logic
    always_comb begin
        n_state     = r_state;
        n_a         = r_a;
        n_x         = r_x;
        n_y         = r_y;
        n_s         = r_s;
        n_p         = P;
        n_pc        = r_pc;
        n_ir        = r_ir;
        n_adl       = r_adl;
        n_address   = r_address;
        n_wr_data   = r_wr_data;
        n_wr_enable = 1'b0;

        case (r_state)
            RST_LO: begin
                n_pc[7:0] = rd_data;
                n_address = RESET_VECTOR_ADDR + 16'd1;
                n_state   = RST_HI;
            end
            RST_HI: begin
                n_pc      = {rd_data, r_pc[7:0]};
                n_address = {rd_data, r_pc[7:0]};
                n_state   = FETCH;
            end
            FETCH: begin
                n_ir      = rd_data;
                n_pc      = w_pc_inc;
                n_address = w_pc_inc;
                n_state   = DECODE;
            end
            DECODE: begin
                case (w_am)
                    // Implied: operand byte was a dummy read, PC stays put
                    AM_IMPL: begin
                        n_address = r_pc;
                        n_state   = FETCH;
                    end
                    AM_IMM: begin
                        n_pc      = w_pc_inc;
                        n_address = w_pc_inc;
                        n_state   = FETCH;
                    end
                    default: begin
                        n_adl     = rd_data;
                        n_pc      = w_pc_inc;
                        n_address = w_pc_inc;
                        n_state   = ABS_HI;
                    end
                endcase
            end
            ABS_HI: begin
                if (w_am == AM_JMP) begin
                    n_pc      = {rd_data, r_adl};
                    n_address = {rd_data, r_adl};
                    n_state   = FETCH;
                end else begin
                    n_pc      = w_pc_inc;
                    n_address = {rd_data, r_adl};
                    if (w_am == AM_ABS_WR) begin
                        n_wr_enable = 1'b1;
                        case (r_ir)
                            OP_STX_ABS: n_wr_data = r_x;
                            OP_STY_ABS: n_wr_data = r_y;
                            default:    n_wr_data = r_a;
                        endcase
                        n_state = EXEC_WR;
                    end else begin
                        n_state = EXEC_RD;
                    end
                end
            end
            EXEC_RD: begin
                n_address = r_pc;
                n_state   = FETCH;
            end
            EXEC_WR: begin
                n_address = r_pc;
                n_state   = FETCH;
            end
            default: n_state = FETCH;
        endcase

        if (w_exec_op) begin
            case (w_kind)
                K_LDA: begin n_a = rd_data; n_p = set_nz(P, rd_data); end
                K_LDX: begin n_x = rd_data; n_p = set_nz(P, rd_data); end
                K_LDY: begin n_y = rd_data; n_p = set_nz(P, rd_data); end
                K_ADC, K_SBC: begin
                    n_a      = w_alu_res;
                    n_p[P_N] = w_alu_n;
                    n_p[P_Z] = w_alu_z;
                    n_p[P_C] = w_alu_c;
                    n_p[P_V] = w_alu_v;
                end
                K_AND, K_ORA, K_EOR: begin
                    n_a = w_alu_res;
                    n_p = set_nz(P, w_alu_res);
                end
                K_CMP, K_CPX, K_CPY: begin
                    n_p      = set_nz(P, w_alu_res);
                    n_p[P_C] = w_alu_c;
                end
                K_BIT: begin
                    n_p[P_Z] = ((r_a & rd_data) == 8'h00);
                    n_p[P_N] = rd_data[7];
                    n_p[P_V] = rd_data[6];
                end
                default: ;
            endcase
        end

        if (w_exec_impl) begin
            case (r_ir)
                OP_TAX: begin n_x = r_a; n_p = set_nz(P, r_a); end
                OP_TXA: begin n_a = r_x; n_p = set_nz(P, r_x); end
                OP_TAY: begin n_y = r_a; n_p = set_nz(P, r_a); end
                OP_TYA: begin n_a = r_y; n_p = set_nz(P, r_y); end
                OP_TSX: begin n_x = r_s; n_p = set_nz(P, r_s); end
                OP_TXS: n_s = r_x;
                OP_INX: begin n_x = r_x + 8'd1; n_p = set_nz(P, r_x + 8'd1); end
                OP_INY: begin n_y = r_y + 8'd1; n_p = set_nz(P, r_y + 8'd1); end
                OP_DEX: begin n_x = r_x - 8'd1; n_p = set_nz(P, r_x - 8'd1); end
                OP_DEY: begin n_y = r_y - 8'd1; n_p = set_nz(P, r_y - 8'd1); end
                OP_CLC: n_p[P_C] = 1'b0;
                OP_SEC: n_p[P_C] = 1'b1;
                OP_CLD: n_p[P_D] = 1'b0;
                OP_SED: n_p[P_D] = 1'b1;
                OP_CLI: n_p[P_I] = 1'b0;
                OP_SEI: n_p[P_I] = 1'b1;
                OP_CLV: n_p[P_V] = 1'b0;
                default: ;
            endcase
        end

        n_p[5] = 1'b1;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= RST_LO;
        else         r_state <= n_state;
    end

    // Architectural registers and bus outputs; reset also drops any pending write
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_a         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_s         <= SP_RESET;
            P           <= 8'h34;
            r_pc        <= '0;
            r_ir        <= '0;
            r_adl       <= '0;
            r_address   <= RESET_VECTOR_ADDR;
            r_wr_data   <= '0;
            r_wr_enable <= 1'b0;
        end else begin
            r_a         <= n_a;
            r_x         <= n_x;
            r_y         <= n_y;
            r_s         <= n_s;
            P           <= n_p;
            r_pc        <= n_pc;
            r_ir        <= n_ir;
            r_adl       <= n_adl;
            r_address   <= n_address;
            r_wr_data   <= n_wr_data;
            r_wr_enable <= n_wr_enable;
        end
    end

endmodule

// File: tb/tb_proc_core.sv
// Self-checking bench for proc_core: directed programs, write scoreboard plus
// cycle-accurate bus and status-register checks.
module tb_proc_core;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  rd_data;
    logic [15:0] address;
    logic [7:0]  wr_data;
    logic        wr_enable;

    logic [7:0]  mem [0:65535];
    logic [7:0]  prog [$];

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;
    wr_t exp_q [$];

    int checks = 0;
    int failures = 0;

    proc_core #(.RESET_VECTOR_ADDR(16'hFFFC), .SP_RESET(8'hFD)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rd_data   (rd_data),
        .address   (address),
        .wr_data   (wr_data),
        .wr_enable (wr_enable)
    );

    always #5 clk = ~clk;

    assign rd_data = mem[address];

    always @(posedge clk) begin
        if (wr_enable) mem[address] = wr_data;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [15:0] a, input logic [7:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [15:0] base);
        for (int i = 0; i < prog.size(); i++) mem[base + 16'(i)] = prog[i];
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Write monitor: every observed write must match the head of the expectation queue
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wr_enable === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write", address, wr_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", address, e.a);
                    chk("wr_data", {8'h00, wr_data}, {8'h00, e.d});
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'hFFFC] = 8'h00;
        mem[16'hFFFD] = 8'h80;
        mem[16'h2000] = 8'h80;
        mem[16'h3000] = 8'h01;
        mem[16'h3002] = 8'h10;
        mem[16'h3005] = 8'hC0;
        prog = '{8'hAD, 8'h00, 8'h20,  8'h8D, 8'h00, 8'h40,  8'hA9, 8'h5A,
                 8'h8D, 8'h34, 8'h12,  8'h18,  8'hA9, 8'h7F,  8'h6D, 8'h00, 8'h30,
                 8'h8D, 8'h01, 8'h40,  8'hA9, 8'h10,  8'hCD, 8'h02, 8'h30,
                 8'h4C, 8'h00, 8'h90};
        load(16'h8000);
        prog = '{8'hA2, 8'hFF,  8'hE8,  8'h8E, 8'h02, 8'h40,  8'hCA,  8'h8A,  8'h38,
                 8'hE9, 8'h0F,  8'h8D, 8'h03, 8'h40,  8'h02,  8'hA0, 8'h33,
                 8'hC0, 8'h40,  8'h8C, 8'h04, 8'h40,  8'h2C, 8'h05, 8'h30,
                 8'h4C, 8'hFE, 8'hFF};
        load(16'h9000);
        mem[16'hFFFE] = 8'hEA;
        mem[16'hFFFF] = 8'hC8;
        prog = '{8'h8C, 8'h05, 8'h40,  8'h4C, 8'h03, 8'h00};
        load(16'h0000);

        expect_wr(16'h4000, 8'h80);
        expect_wr(16'h1234, 8'h5A);
        expect_wr(16'h4001, 8'h80);
        expect_wr(16'h4002, 8'h00);
        expect_wr(16'h4003, 8'hF0);
        expect_wr(16'h4004, 8'h33);
        expect_wr(16'h4005, 8'h34);

        // Reset held for 4 cycles
        step(4);
        chk("rst_address", address, 16'hFFFC);
        chk("rst_wr_enable", {15'd0, wr_enable}, 16'd0);
        chk("rst_wr_data", {8'h00, wr_data}, 16'h0000);
        chk("rst_P", {8'h00, dut.P}, 16'h0034);
        resetn = 1'b1;

        step(1); chk("vec_hi_address", address, 16'hFFFD);
        step(1); chk("first_fetch", address, 16'h8000);
        step(3); chk("lda_abs_operand_addr", address, 16'h2000);
        step(1); chk("lda_abs_next_fetch", address, 16'h8003);
        chk("lda_abs_A", {8'h00, dut.r_a}, 16'h0080);
        chk("lda_abs_P", {8'h00, dut.P}, 16'h00B4);
        step(3); chk("sta_we_high", {15'd0, wr_enable}, 16'd1);
        step(1); chk("sta_we_low_after", {15'd0, wr_enable}, 16'd0);
        step(14); chk("adc_next_fetch", address, 16'h8011);
        chk("adc_P", {8'h00, dut.P}, 16'h00F4);
        step(10); chk("cmp_next_fetch", address, 16'h8019);
        chk("cmp_P", {8'h00, dut.P}, 16'h0077);
        step(2); chk("jmp_t2_addr", address, 16'h801B);
        step(1); chk("jmp_target_fetch", address, 16'h9000);
        step(80);
        chk("mem_1234", {8'h00, mem[16'h1234]}, 16'h005A);
        chk("final_P", {8'h00, dut.P}, 16'h0074);
        chk("phase1_writes_done", 16'(exp_q.size()), 16'd0);

        // Mid-instruction reset during T2 of a store
        resetn = 1'b0;
        mem[16'hFFFD] = 8'hA0;
        prog = '{8'hA9, 8'h77,  8'h8D, 8'h00, 8'h50,  8'h4C, 8'h05, 8'hA0};
        load(16'hA000);
        step(2);
        expect_wr(16'h5000, 8'h77);
        resetn = 1'b1;
        step(6); chk("sta_t2_addr", address, 16'hA004);
        resetn = 1'b0;
        #1;
        chk("abort_address", address, 16'hFFFC);
        chk("abort_we", {15'd0, wr_enable}, 16'd0);
        step(2);
        chk("abort_no_write", {8'h00, mem[16'h5000]}, 16'h0000);
        resetn = 1'b1;
        step(1); chk("restart_vec_hi", address, 16'hFFFD);
        step(1); chk("restart_fetch", address, 16'hA000);
        step(20);
        chk("mem_5000", {8'h00, mem[16'h5000]}, 16'h0077);
        chk("phase2_writes_done", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
